led_shift_scan_ctrl: RTL and testbench
======================================

// Module: led_shift_scan_ctrl
// PURPOSE
//  Parametrised LED pattern shifter plus multiplexed 7-segment status display.
//  Rotates an LED_W-bit pattern left, right or ping-pong (bounce), or holds it, at a selectable fast/slow rate.
//  Scans DIGITS common-anode digits showing speed and mode.
//  Fully synchronous: all rates are clock-enable ticks off one CLK; no derived clocks. Top-level board I/O block.
// PARAMETERS
//  LED_W      16        LED pattern width (>=2)
//  DIGITS     6         number of scanned digits (>=2)
//  SCAN_DIV   2048      CLK cycles per digit advance (>=2)
//  FAST_DIV   524288    CLK cycles per shift step, fast speed (>=2)
//  SLOW_DIV   2097152   CLK cycles per shift step, slow speed (>=2)
//  RST_PAT    16'hFFF0  LED pattern after reset (LED_W bits)
// PORTS
//  CLK        in   1       system clock
//  RESET      in   1       synchronous reset, active-high
//  MODE_SEL   in   2       00 rotate-left, 01 rotate-right, 10 bounce, 11 hold
//  SPEED_SEL  in   1       0 slow (SLOW_DIV), 1 fast (FAST_DIV)
//  LOAD       in   1       1-cycle strobe: replace pattern with LOAD_DATA
//  LOAD_DATA  in   LED_W   pattern to load
//  LED        out  LED_W   current pattern, registered
//  STEP_TICK  out  1       1-cycle pulse in the cycle LED takes a shifted value
//  SEGMENT    out  8       active-low {dp,g,f,e,d,c,b,a}, registered
//  ENABLE     out  DIGITS  active-low one-cold digit select, registered
// BEHAVIOUR
//  Reset (CLK edge with RESET=1): LED=RST_PAT; STEP_TICK=0; ENABLE={1..1,0} (digit0);
//   SEGMENT=code(digit0); all counters=0; dir=left; bounce count=0.
//  Step prescaler:
//   - counts 0..DIV-1, DIV = SPEED_SEL ? FAST_DIV : SLOW_DIV; step occurs when count==DIV-1, count->0.
//   - SPEED_SEL change restarts count at 0 next cycle; no step that cycle.
//   - If count>=DIV (e.g. after switching slow->fast), that is the same restart case.
//  On step:
//   - left: LED<={LED[LED_W-2:0],LED[LED_W-1]}; right: LED<={LED[0],LED[LED_W-1:1]}.
//   - bounce: shift in dir; bcnt++; when bcnt reaches LED_W-1, dir flips and bcnt->0 (LED_W-1 steps per sweep).
//   - hold: LED unchanged, STEP_TICK=0, prescaler keeps running.
//  Bounce state:
//   - entering bounce (MODE_SEL becomes 10) starts with dir=left, bcnt=0.
//   - leaving bounce clears bcnt, dir=left.
//  LOAD:
//   - LED<=LOAD_DATA next cycle; wins over a simultaneous step (STEP_TICK=0 that cycle).
//   - bcnt->0, dir unchanged; prescaler not disturbed.
//  STEP_TICK: registered, high exactly in the cycle LED shows the new shifted value.
//  Scan:
//   - scan counter 0..SCAN_DIV-1; at wrap, ENABLE rotates one place left (digit k -> k+1, DIGITS-1 -> 0).
//   - SEGMENT updated in the same cycle, so digit select and data always match (no ghosting cycle).
//  Digit content:
//   - digit0: speed, S=8'b10010010 / F=8'b10001110.
//   - digit1: mode, L=8'b11000111, r=8'b10101111, b=8'b10000011 + dp lit when dir=right (bit7=0), H=8'b10001001.
//   - digits>=2: blank 8'hFF.
//  Inputs MODE_SEL/SPEED_SEL sampled every cycle; display reflects them within one scan period.
//  Reset mid-sweep: immediately restores the reset state above regardless of tick/LOAD.
// TESTING (sim with FAST_DIV=4, SLOW_DIV=8, SCAN_DIV=3, LED_W=8, RST_PAT=8'hF0, DIGITS=4)
//  1. Reset, MODE=00, SPEED=1: LED F0->E1->C3 at steps; STEP_TICK every 4th cycle.
//  2. MODE=10 from 8'h01: 7 left steps to 8'h80, then dir flips; next step 8'h40. bcnt wraps at 7.
//  3. LOAD=1, LOAD_DATA=8'hA5 in the step cycle -> LED=A5, STEP_TICK=0; next step after prescaler wrap.
//  4. SPEED 0->1 at count 6 -> no step that cycle; first fast step exactly 4 cycles later.
//  5. Scan: ENABLE E->D->B->7->E every 3 cycles; digit0 SEGMENT=8E (fast), digit1=C7 (left), digits2-3=FF.
//  6. RESET asserted mid-bounce (dir=right) -> next cycle LED=F0, ENABLE=E, dir=left, STEP_TICK=0.

Source files
------------

// File: rtl/led_shift_scan_ctrl.sv
// LED pattern shifter with a multiplexed common-anode 7-segment status display.
// The pattern rotates left, right, ping-pong (bounce) or holds, stepping on a
// slow/fast clock-enable prescaler. All rates are derived from CLK by counters.
// Ports:
//   CLK        system clock
//   RESET      synchronous reset, active-high
//   MODE_SEL   00 rotate-left, 01 rotate-right, 10 bounce, 11 hold
//   SPEED_SEL  0 slow (SLOW_DIV), 1 fast (FAST_DIV)
//   LOAD       single-cycle strobe replacing the pattern with LOAD_DATA
//   LOAD_DATA  pattern to load
//   LED        current pattern (registered)
//   STEP_TICK  high in the cycle LED shows a newly shifted value (registered)
//   SEGMENT    active-low {dp,g,f,e,d,c,b,a} (registered)
//   ENABLE     active-low one-cold digit select (registered)
module led_shift_scan_ctrl #(
  parameter int unsigned      LED_W    = 16,
  parameter int unsigned      DIGITS   = 6,
  parameter int unsigned      SCAN_DIV = 2048,
  parameter int unsigned      FAST_DIV = 524288,
  parameter int unsigned      SLOW_DIV = 2097152,
  parameter logic [LED_W-1:0] RST_PAT  = LED_W'(16'hFFF0)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        MODE_SEL,
  input  logic              SPEED_SEL,
  input  logic              LOAD,
  input  logic [LED_W-1:0]  LOAD_DATA,
  output logic [LED_W-1:0]  LED,
  output logic              STEP_TICK,
  output logic [7:0]        SEGMENT,
  output logic [DIGITS-1:0] ENABLE
);

  localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int unsigned CNT_W   = $clog2(MAX_DIV + 1);
  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W   = $clog2(DIGITS);
  localparam int unsigned BCNT_W  = $clog2(LED_W);

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  localparam logic [7:0] SEG_S     = 8'b10010010;
  localparam logic [7:0] SEG_F     = 8'b10001110;
  localparam logic [7:0] SEG_L     = 8'b11000111;
  localparam logic [7:0] SEG_R     = 8'b10101111;
  localparam logic [7:0] SEG_B     = 8'b10000011;
  localparam logic [7:0] SEG_H     = 8'b10001001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

  logic [LED_W-1:0]  led_q,   led_d;
  logic              tick_q,  tick_d;
  logic [7:0]        seg_q,   seg_d;
  logic [DIGITS-1:0] en_q,    en_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              speed_q, speed_d;
  logic [SCAN_W-1:0] scan_q,  scan_d;
  logic [DIG_W-1:0]  dig_q,   dig_d;
  logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
  dir_e              dir_q,   dir_d;

  logic [CNT_W-1:0]  div_c;
  logic              step_c;
  logic [LED_W-1:0]  rotl_c, rotr_c;

  // Segment pattern for a digit given the live speed/mode and bounce direction.
  function automatic logic [7:0] seg_code(input logic [DIG_W-1:0] dig,
                                          input logic             spd,
                                          input logic [1:0]       mode,
                                          input dir_e             dir);
    logic [7:0] code;
    code = SEG_BLANK;
    if (dig == DIG_W'(0)) begin
      code = spd ? SEG_F : SEG_S;
    end else if (dig == DIG_W'(1)) begin
      case (mode)
        MODE_LEFT:   code = SEG_L;
        MODE_RIGHT:  code = SEG_R;
        MODE_BOUNCE: code = (dir == DIR_RIGHT) ? {1'b0, SEG_B[6:0]} : SEG_B;
        default:     code = SEG_H;
      endcase
    end
    return code;
  endfunction

  // State registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q   <= RST_PAT;
      tick_q  <= 1'b0;
      seg_q   <= SPEED_SEL ? SEG_F : SEG_S;
      en_q    <= ~DIGITS'(1);
      cnt_q   <= '0;
      speed_q <= SPEED_SEL;
      scan_q  <= '0;
      dig_q   <= '0;
      bcnt_q  <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      led_q   <= led_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      bcnt_q  <= bcnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state: prescaler, pattern/bounce control and display scan.
  always_comb begin
    led_d   = led_q;
    tick_d  = 1'b0;
    cnt_d   = cnt_q;
    speed_d = SPEED_SEL;
    scan_d  = scan_q;
    dig_d   = dig_q;
    bcnt_d  = bcnt_q;
    dir_d   = dir_q;
    step_c  = 1'b0;

    div_c  = SPEED_SEL ? CNT_W'(FAST_DIV) : CNT_W'(SLOW_DIV);
    rotl_c = {led_q[LED_W-2:0], led_q[LED_W-1]};
    rotr_c = {led_q[0], led_q[LED_W-1:1]};

    // A speed change or an out-of-range count (slow->fast) restarts without a step.
    if ((SPEED_SEL != speed_q) || (cnt_q >= div_c)) begin
      cnt_d = '0;
    end else if (cnt_q == div_c - CNT_W'(1)) begin
      cnt_d  = '0;
      step_c = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (LOAD) begin
      led_d  = LOAD_DATA;
      bcnt_d = '0;
    end else if (step_c) begin
      case (MODE_SEL)
        MODE_LEFT: begin
          led_d  = rotl_c;
          tick_d = 1'b1;
        end
        MODE_RIGHT: begin
          led_d  = rotr_c;
          tick_d = 1'b1;
        end
        MODE_BOUNCE: begin
          led_d  = (dir_q == DIR_LEFT) ? rotl_c : rotr_c;
          tick_d = 1'b1;
          // LED_W-1 steps per sweep, then reverse.
          if (bcnt_q == BCNT_W'(LED_W - 2)) begin
            bcnt_d = '0;
            dir_d  = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Outside bounce the sweep state is parked so re-entry starts fresh.
    if (MODE_SEL != MODE_BOUNCE) begin
      bcnt_d = '0;
      dir_d  = DIR_LEFT;
    end

    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      dig_d  = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
    end else begin
      scan_d = scan_q + SCAN_W'(1);
    end

    // Select and data are both derived from the next digit, so they change together.
    en_d  = ~(DIGITS'(1) << dig_d);
    seg_d = seg_code(dig_d, SPEED_SEL, MODE_SEL, dir_d);
  end

  assign LED       = led_q;
  assign STEP_TICK = tick_q;
  assign SEGMENT   = seg_q;
  assign ENABLE    = en_q;

endmodule

// File: tb/tb_led_shift_scan_ctrl.sv
// Testbench for led_shift_scan_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the pattern and display.
module tb_led_shift_scan_ctrl;

  localparam int unsigned LED_W    = 8;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 3;
  localparam int unsigned FAST_DIV = 4;
  localparam int unsigned SLOW_DIV = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              spd;
  logic              load;
  logic [LED_W-1:0]  ldata;
  logic [LED_W-1:0]  led;
  logic              tick;
  logic [7:0]        seg;
  logic [DIGITS-1:0] en;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  int   m_led, m_phase, m_prev_spd, m_dir, m_bcnt, m_scan_t;
  bit   m_tick;
  logic [7:0] m_seg;
  logic [3:0] m_en;

  always #5 clk = ~clk;

  led_shift_scan_ctrl #(
    .LED_W   (LED_W),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .FAST_DIV(FAST_DIV),
    .SLOW_DIV(SLOW_DIV),
    .RST_PAT (8'hF0)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .MODE_SEL (mode),
    .SPEED_SEL(spd),
    .LOAD     (load),
    .LOAD_DATA(ldata),
    .LED      (led),
    .STEP_TICK(tick),
    .SEGMENT  (seg),
    .ENABLE   (en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rotl(input int x);
    return ((x << 1) | (x >> (LED_W - 1))) & 'hFF;
  endfunction

  function automatic int rotr(input int x);
    return ((x >> 1) | (x << (LED_W - 1))) & 'hFF;
  endfunction

  // Display expectations from the elapsed scan time and live inputs.
  task automatic model_display();
    int d;
    d = m_scan_t / SCAN_DIV;
    m_en = 4'((~(1 << d)) & 'hF);
    if (d == 0)      m_seg = spd ? 8'h8E : 8'h92;
    else if (d == 1) begin
      case (mode)
        2'd0:    m_seg = 8'hC7;
        2'd1:    m_seg = 8'hAF;
        2'd2:    m_seg = (m_dir != 0) ? 8'h03 : 8'h83;
        default: m_seg = 8'h89;
      endcase
    end else m_seg = 8'hFF;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    int div;
    bit step;
    if (rst) begin
      m_led = 'hF0; m_tick = 0; m_phase = 0; m_prev_spd = int'(spd);
      m_dir = 0; m_bcnt = 0; m_scan_t = 0;
      model_display();
      return;
    end
    div  = spd ? FAST_DIV : SLOW_DIV;
    step = 0;
    if (int'(spd) != m_prev_spd || m_phase >= div) m_phase = 0;
    else if (m_phase == div - 1) begin m_phase = 0; step = 1; end
    else m_phase++;
    m_prev_spd = int'(spd);
    m_tick = 0;
    if (load) begin
      m_led = int'(ldata); m_bcnt = 0;
    end else if (step && mode != 2'd3) begin
      m_tick = 1;
      if (mode == 2'd0 || (mode == 2'd2 && m_dir == 0)) m_led = rotl(m_led);
      else m_led = rotr(m_led);
      if (mode == 2'd2) begin
        m_bcnt++;
        if (m_bcnt == LED_W - 1) begin m_dir ^= 1; m_bcnt = 0; end
      end
    end
    if (mode != 2'd2) begin m_dir = 0; m_bcnt = 0; end
    m_scan_t = (m_scan_t + 1) % (SCAN_DIV * DIGITS);
    model_display();
  endtask

  // One clock: model update at the edge, DUT sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("led",  32'(led),  32'(m_led));
    check("tick", 32'(tick), 32'(m_tick));
    check("seg",  32'(seg),  32'(m_seg));
    check("en",   32'(en),   32'(m_en));
  endtask

  initial begin
    int n, guard;
    rst = 1'b1; mode = 2'd0; spd = 1'b1; load = 1'b0; ldata = '0;

    // Reset state and fast rotate-left: F0 -> E1 -> C3.
    cycle();
    cycle();
    check("rst_led", 32'(led), 32'h F0);
    check("rst_en",  32'(en),  32'h E);
    check("rst_seg", 32'(seg), 32'h 8E);
    check("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (i == 4) begin
        check("rotl_1", 32'(led), 32'hE1);
        check("rotl_1_tick", 32'(tick), 32'h1);
      end
      if (i == 3) check("en_d", 32'(en), 32'hD);
      if (i == 6) check("en_b", 32'(en), 32'hB);
    end
    check("rotl_2", 32'(led), 32'hC3);

    // Bounce from 01: seven left steps to 80, then the first right step to 40.
    mode = 2'd2; load = 1'b1; ldata = 8'h01;
    cycle();
    load = 1'b0;
    n = 0; guard = 0;
    while (n < 7 && guard < 100) begin cycle(); if (m_tick) n++; guard++; end
    check("bounce_wait", 32'(n), 32'd7);
    check("bounce_top", 32'(led), 32'h80);
    n = 0; guard = 0;
    while (n < 1 && guard < 100) begin cycle(); if (m_tick) n++; guard++; end
    check("bounce_back", 32'(led), 32'h40);

    // Reset while sweeping right.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_led", 32'(led), 32'hF0);
    check("midrst_en",  32'(en),  32'hE);
    check("midrst_tick", 32'(tick), 32'h0);
    for (int i = 0; i < 12; i++) cycle();

    // LOAD coincident with a step wins and suppresses STEP_TICK.
    mode = 2'd0; spd = 1'b1;
    guard = 0;
    while (m_phase != FAST_DIV - 1 && guard < 20) begin cycle(); guard++; end
    check("load_align", 32'(m_phase), 32'(FAST_DIV - 1));
    load = 1'b1; ldata = 8'hA5;
    cycle();
    load = 1'b0;
    check("load_led", 32'(led), 32'hA5);
    check("load_tick", 32'(tick), 32'h0);
    for (int i = 0; i < 4; i++) cycle();
    check("load_next", 32'(led), 32'h4B);
    check("load_next_tick", 32'(tick), 32'h1);

    // Slow -> fast switch at count 6: no step, then a fast step four cycles later.
    spd = 1'b0;
    guard = 0;
    cycle();
    while (m_phase != 6 && guard < 20) begin cycle(); guard++; end
    check("sw_align", 32'(m_phase), 32'd6);
    spd = 1'b1;
    cycle();
    check("sw_notick", 32'(tick), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check("sw_tick", 32'(tick), (k == 4) ? 32'h1 : 32'h0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) spd = ~spd;
      load  = ($urandom_range(0, 15) == 0);
      ldata = 8'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
